// File: rtl/npu_telemetry_aggregator_if.sv
// npu_telemetry_aggregator_if
//   Host-side CSR request/response bus plus the fan-out bus to the tiles'
//   CSR blocks, bundled so the aggregator takes it as a single port.
//   Host side : csr_valid, csr_write, csr_bcast, csr_addr, csr_wdata (request)
//               csr_rdata, csr_ready, csr_err (response)
//   Tile side : tile_csr_valid (one per tile), tile_csr_write, tile_csr_addr,
//               tile_csr_wdata (request); tile_csr_rdata_flat, tile_csr_ready
//               (response, tile i data at [32i+31:32i])
//   master : host plus tile models (drives requests, drives tile responses)
//   slave  : the aggregator
interface npu_telemetry_aggregator_if #(
    parameter int NUM_TILES = 4,
    parameter int ADDR_W    = 8
);
    logic                    csr_valid;
    logic                    csr_write;
    logic                    csr_bcast;
    logic [ADDR_W-1:0]       csr_addr;
    logic [31:0]             csr_wdata;
    logic [31:0]             csr_rdata;
    logic                    csr_ready;
    logic                    csr_err;

    logic [NUM_TILES-1:0]    tile_csr_valid;
    logic                    tile_csr_write;
    logic [ADDR_W-1:0]       tile_csr_addr;
    logic [31:0]             tile_csr_wdata;
    logic [NUM_TILES*32-1:0] tile_csr_rdata_flat;
    logic [NUM_TILES-1:0]    tile_csr_ready;

    modport master (
        output csr_valid, csr_write, csr_bcast, csr_addr, csr_wdata,
        input  csr_rdata, csr_ready, csr_err,
        input  tile_csr_valid, tile_csr_write, tile_csr_addr, tile_csr_wdata,
        output tile_csr_rdata_flat, tile_csr_ready
    );

    modport slave (
        input  csr_valid, csr_write, csr_bcast, csr_addr, csr_wdata,
        output csr_rdata, csr_ready, csr_err,
        output tile_csr_valid, tile_csr_write, tile_csr_addr, tile_csr_wdata,
        input  tile_csr_rdata_flat, tile_csr_ready
    );
endinterface

// File: rtl/npu_telemetry_aggregator.sv
// npu_telemetry_aggregator
//   Snapshots per-tile ops/power counters, sums them with saturation and
//   computes system efficiency (milli-TOPS/W) with a serial restoring divider.
//   Independently bridges host CSR accesses to one tile or (writes) all tiles,
//   with a response timeout.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   snap_req          start a snapshot (ignored unless idle)
//   snap_busy         snapshot engine not idle
//   snap_done         one-cycle pulse, sys_* updated in this cycle
//   tile_ops_flat     NUM_TILES x 32-bit ops counters
//   tile_power_flat   NUM_TILES x 16-bit power (mW)
//   tile_ready        per-tile ready; sys_ready is their registered AND
//   sys_ops, sys_power, sys_eff_milli   snapshot results
//   csr               host/tile CSR bus (slave modport)
module npu_telemetry_aggregator #(
    parameter int NUM_TILES   = 4,
    parameter int ADDR_W      = 8,
    parameter int CSR_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    snap_req,
    output logic                    snap_busy,
    output logic                    snap_done,
    input  logic [NUM_TILES*32-1:0] tile_ops_flat,
    input  logic [NUM_TILES*16-1:0] tile_power_flat,
    input  logic [NUM_TILES-1:0]    tile_ready,
    output logic [31:0]             sys_ops,
    output logic [15:0]             sys_power,
    output logic [15:0]             sys_eff_milli,
    output logic                    sys_ready,
    npu_telemetry_aggregator_if.slave csr
);
    localparam int TSEL_W = $clog2(NUM_TILES);
    localparam int TMR_W  = $clog2(CSR_TIMEOUT + 1);

    // ---------------- snapshot engine ----------------
    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} snap_state_t;
    snap_state_t snap_state, snap_next;

    logic [5:0]  cnt;
    logic [31:0] cap_ops [NUM_TILES];
    logic [15:0] cap_pwr [NUM_TILES];
    logic [31:0] acc_ops;
    logic [15:0] acc_pwr;
    logic [31:0] rem, quo;

    logic        last_tile, last_step;
    logic [32:0] ops_add;
    logic [16:0] pwr_add;
    logic [31:0] dividend;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_nx, quo_nx;
    logic [15:0] eff_sat;

    assign last_tile = (cnt == 6'(NUM_TILES - 1));
    // DIV cycle 0 loads the dividend, cycles 1..32 each retire one quotient bit
    assign last_step = (cnt == 6'd32);
    assign snap_busy = (snap_state != IDLE);
    assign snap_done = (snap_state == DONE);

    always_comb begin
        ops_add  = {1'b0, acc_ops} + {1'b0, cap_ops[cnt[TSEL_W-1:0]]};
        pwr_add  = {1'b0, acc_pwr} + {1'b0, cap_pwr[cnt[TSEL_W-1:0]]};
        dividend = {10'd0, acc_ops[31:10]} * 32'd1000;
        // Divisor is at most 16 bits, so the remainder never needs more than
        // 32 bits; a zero divisor yields an all-ones quotient, i.e. 0xFFFF.
        rem_sh   = {rem, quo[31]};
        ge       = (rem_sh >= {17'd0, acc_pwr});
        rem_nx   = ge ? (rem_sh[31:0] - {16'd0, acc_pwr}) : rem_sh[31:0];
        quo_nx   = {quo[30:0], ge};
        eff_sat  = (|quo_nx[31:16]) ? 16'hFFFF : quo_nx[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) snap_state <= IDLE;
        else       snap_state <= snap_next;
    end

    always_comb begin
        snap_next = snap_state;
        case (snap_state)
            IDLE:    if (snap_req) snap_next = SUM;
            SUM:     if (last_tile) snap_next = DIV;
            DIV:     if (last_step) snap_next = DONE;
            default: snap_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            acc_ops       <= '0;
            acc_pwr       <= '0;
            rem           <= '0;
            quo           <= '0;
            sys_ops       <= '0;
            sys_power     <= '0;
            sys_eff_milli <= '0;
            for (int i = 0; i < NUM_TILES; i++) begin
                cap_ops[i] <= '0;
                cap_pwr[i] <= '0;
            end
        end else begin
            case (snap_state)
                IDLE: begin
                    if (snap_req) begin
                        for (int i = 0; i < NUM_TILES; i++) begin
                            cap_ops[i] <= tile_ops_flat[32*i +: 32];
                            cap_pwr[i] <= tile_power_flat[16*i +: 16];
                        end
                        acc_ops <= '0;
                        acc_pwr <= '0;
                        cnt     <= '0;
                    end
                end
                SUM: begin
                    acc_ops <= ops_add[32] ? 32'hFFFF_FFFF : ops_add[31:0];
                    acc_pwr <= pwr_add[16] ? 16'hFFFF : pwr_add[15:0];
                    cnt     <= last_tile ? 6'd0 : cnt + 6'd1;
                end
                DIV: begin
                    if (cnt == 6'd0) begin
                        quo <= dividend;
                        rem <= '0;
                    end else begin
                        quo <= quo_nx;
                        rem <= rem_nx;
                    end
                    cnt <= cnt + 6'd1;
                    if (last_step) begin
                        sys_ops       <= acc_ops;
                        sys_power     <= acc_pwr;
                        sys_eff_milli <= eff_sat;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sys_ready <= 1'b0;
        else       sys_ready <= &tile_ready;
    end

    // ---------------- CSR bridge ----------------
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RESP} csr_state_t;
    csr_state_t cstate, cnext;

    logic [ADDR_W-1:0]    addr_q;
    logic [31:0]          wdata_q;
    logic                 write_q;
    logic [NUM_TILES-1:0] target, acked, acked_nx, tvalid, req_mask;
    logic [TMR_W-1:0]     timer;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic [TSEL_W-1:0]    sel, sel_in;
    logic [31:0]          sel_rdata;
    logic                 complete, timed_out;

    assign sel       = addr_q[ADDR_W-1 -: TSEL_W];
    assign sel_in    = csr.csr_addr[ADDR_W-1 -: TSEL_W];
    // Readies are remembered per tile so a broadcast completes even when the
    // tiles answer in different cycles.
    assign acked_nx  = acked | (csr.tile_csr_ready & tvalid);
    assign complete  = ((acked_nx & target) == target);
    assign timed_out = (timer == TMR_W'(CSR_TIMEOUT - 1));

    always_comb begin
        req_mask = '0;
        if (csr.csr_bcast && csr.csr_write) req_mask = '1;
        else                                req_mask[sel_in] = 1'b1;
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (sel == TSEL_W'(i)) sel_rdata = csr.tile_csr_rdata_flat[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cstate <= C_IDLE;
        else       cstate <= cnext;
    end

    always_comb begin
        cnext = cstate;
        case (cstate)
            C_IDLE:  if (csr.csr_valid) cnext = C_WAIT;
            C_WAIT:  if (complete || timed_out) cnext = C_RESP;
            default: cnext = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            target  <= '0;
            acked   <= '0;
            tvalid  <= '0;
            timer   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (cstate)
                C_IDLE: begin
                    if (csr.csr_valid) begin
                        addr_q  <= csr.csr_addr;
                        wdata_q <= csr.csr_wdata;
                        write_q <= csr.csr_write;
                        target  <= req_mask;
                        tvalid  <= req_mask;
                        acked   <= '0;
                        timer   <= '0;
                    end
                end
                C_WAIT: begin
                    acked <= acked_nx;
                    if (complete) begin
                        tvalid  <= '0;
                        rdata_q <= write_q ? 32'd0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        tvalid  <= '0;
                        rdata_q <= 32'hDEAD_BEEF;
                        err_q   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign csr.csr_ready      = (cstate == C_RESP);
    assign csr.csr_rdata      = rdata_q;
    assign csr.csr_err        = err_q;
    assign csr.tile_csr_valid = tvalid;
    assign csr.tile_csr_write = write_q;
    assign csr.tile_csr_addr  = addr_q;
    assign csr.tile_csr_wdata = wdata_q;
endmodule

// File: tb/tb_npu_telemetry_aggregator.sv
// tb_npu_telemetry_aggregator
//   Bench for npu_telemetry_aggregator (NUM_TILES=4, ADDR_W=8, CSR_TIMEOUT=64):
//   snapshot vectors from a table (fixed corner cases plus random entries
//   scored by an arithmetic model), back-to-back and aborted snapshots, and
//   CSR reads, writes, broadcasts and timeouts against simple tile responders.
module tb_npu_telemetry_aggregator;
    localparam int NT = 4;
    localparam int AW = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                snap_req, snap_busy, snap_done;
    logic [NT-1:0][31:0] ops_in;
    logic [NT-1:0][15:0] pwr_in;
    logic [NT-1:0]       tile_ready;
    logic [31:0]         sys_ops;
    logic [15:0]         sys_power, sys_eff;
    logic                sys_ready;

    npu_telemetry_aggregator_if #(.NUM_TILES(NT), .ADDR_W(AW)) bus ();

    npu_telemetry_aggregator #(.NUM_TILES(NT), .ADDR_W(AW), .CSR_TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .snap_req       (snap_req),
        .snap_busy      (snap_busy),
        .snap_done      (snap_done),
        .tile_ops_flat  (ops_in),
        .tile_power_flat(pwr_in),
        .tile_ready     (tile_ready),
        .sys_ops        (sys_ops),
        .sys_power      (sys_power),
        .sys_eff_milli  (sys_eff),
        .sys_ready      (sys_ready),
        .csr            (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- tile CSR responders ----------------
    logic [NT-1:0] t_en;
    int            t_dly [NT];
    logic [31:0]   t_val [NT];
    int            t_cnt [NT];
    logic [NT-1:0] t_acked;
    int            wr_count [NT] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (reset) begin
                bus.tile_csr_ready[i] = 1'b0;
                bus.tile_csr_rdata_flat[32*i +: 32] = 32'd0;
                t_acked[i] = 1'b0;
                t_cnt[i] = 0;
            end else if (bus.tile_csr_valid[i] && !t_acked[i]) begin
                t_cnt[i]++;
                if (t_en[i] && t_cnt[i] >= t_dly[i]) begin
                    bus.tile_csr_ready[i] = 1'b1;
                    bus.tile_csr_rdata_flat[32*i +: 32] = t_val[i];
                    t_acked[i] = 1'b1;
                    if (bus.tile_csr_write) wr_count[i]++;
                end
            end else begin
                bus.tile_csr_ready[i] = 1'b0;
                if (!bus.tile_csr_valid[i]) begin
                    t_acked[i] = 1'b0;
                    t_cnt[i] = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [NT-1:0][31:0] o, input logic [NT-1:0][15:0] p,
                                  output logic [31:0] eo, output logic [15:0] ep,
                                  output logic [15:0] ee);
        longint unsigned so = 0, sp = 0, dvd, q;
        for (int i = 0; i < NT; i++) begin
            so += longint'(o[i]);
            sp += longint'(p[i]);
        end
        if (so > 64'hFFFF_FFFF) so = 64'hFFFF_FFFF;
        if (sp > 64'hFFFF) sp = 64'hFFFF;
        dvd = ((so >> 10) * 1000) % (64'd1 << 32);
        if (sp == 0) q = 65535;
        else         q = dvd / sp;
        if (q > 65535) q = 65535;
        eo = 32'(so);
        ep = 16'(sp);
        ee = 16'(q);
    endfunction

    typedef struct {
        logic [NT-1:0][31:0] ops;
        logic [NT-1:0][15:0] pwr;
        logic [31:0]         e_ops;
        logic [15:0]         e_pwr;
        logic [15:0]         e_eff;
    } vec_t;
    vec_t vt [12];

    task automatic run_snap(input logic [NT-1:0][31:0] o, input logic [NT-1:0][15:0] p,
                            input logic [31:0] eo, input logic [15:0] ep,
                            input logic [15:0] ee, input string tag);
        int k;
        @(negedge clk);
        ops_in   = o;
        pwr_in   = p;
        snap_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        snap_req = 1'b0;
        ops_in   = {$urandom, $urandom, $urandom, $urandom};
        pwr_in   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        chk({tag, "_busy"}, snap_busy, 1'b1);
        k = 0;
        while (!snap_done && k < 200) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, NT + 33);
        chk({tag, "_ops"}, sys_ops, eo);
        chk({tag, "_pwr"}, sys_power, ep);
        chk({tag, "_eff"}, sys_eff, ee);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {snap_done, snap_busy}, 2'b00);
    endtask

    task automatic csr_txn(input logic wr, input logic bc, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [NT-1:0] exp_mask,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input string tag);
        int k;
        @(negedge clk);
        bus.csr_valid = 1'b1;
        bus.csr_write = wr;
        bus.csr_bcast = bc;
        bus.csr_addr  = addr;
        bus.csr_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.csr_valid = 1'b0;
        chk({tag, "_tvalid"}, bus.tile_csr_valid, exp_mask);
        k = 0;
        while (!bus.csr_ready && k < 200) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, bus.csr_ready, 1'b1);
        if (exp_lat >= 0) chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_rdata"}, bus.csr_rdata, exp_rd);
        chk({tag, "_err"}, bus.csr_err, exp_err);
        chk({tag, "_tvalid_drop"}, bus.tile_csr_valid, '0);
        @(negedge clk);
        chk({tag, "_ready_pulse"}, bus.csr_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nd, nr, k;
        int wc [NT];
        logic [NT-1:0] rdy_pat [4];
        logic          rdy_exp [4];

        // fixed corner cases
        vt[0].ops = {4{32'h0010_0000}}; vt[0].pwr = {4{16'd100}};
        vt[0].e_ops = 32'h0040_0000; vt[0].e_pwr = 16'd400; vt[0].e_eff = 16'd10240;
        vt[1].ops = {4{32'h0010_0000}}; vt[1].pwr = {4{16'd0}};
        vt[1].e_ops = 32'h0040_0000; vt[1].e_pwr = 16'd0; vt[1].e_eff = 16'hFFFF;
        vt[2].ops = {4{32'hFFFF_FFFF}}; vt[2].pwr = {4{16'd1000}};
        vt[2].e_ops = 32'hFFFF_FFFF; vt[2].e_pwr = 16'd4000; vt[2].e_eff = 16'hFFFF;
        vt[3].ops = {4{32'h0010_0000}}; vt[3].pwr = {4{16'h8000}};
        vt[3].e_ops = 32'h0040_0000; vt[3].e_pwr = 16'hFFFF; vt[3].e_eff = 16'd62;
        // random entries scored by the model
        for (int j = 4; j < 12; j++) begin
            for (int i = 0; i < NT; i++) begin
                vt[j].ops[i] = (j % 3 == 0) ? ($urandom | 32'hC000_0000)
                                            : 32'($urandom_range(0, 32'h03FF_FFFF));
                vt[j].pwr[i] = (j == 5) ? 16'd0
                                        : 16'($urandom_range(1, (j % 2 == 1) ? 40000 : 2000));
            end
            model(vt[j].ops, vt[j].pwr, vt[j].e_ops, vt[j].e_pwr, vt[j].e_eff);
        end

        rdy_pat[0] = 4'b1111; rdy_exp[0] = 1'b1;
        rdy_pat[1] = 4'b1011; rdy_exp[1] = 1'b0;
        rdy_pat[2] = 4'b1111; rdy_exp[2] = 1'b1;
        rdy_pat[3] = 4'b0000; rdy_exp[3] = 1'b0;

        reset         = 1'b1;
        snap_req      = 1'b0;
        ops_in        = '0;
        pwr_in        = '0;
        tile_ready    = 4'b1111;
        bus.csr_valid = 1'b0;
        bus.csr_write = 1'b0;
        bus.csr_bcast = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        t_en = 4'b1111;
        for (int i = 0; i < NT; i++) begin
            t_dly[i] = 2;
            t_val[i] = 32'h1000 + 32'(i);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", snap_busy, 1'b0);
        chk("rst_done", snap_done, 1'b0);
        chk("rst_sys", {sys_ops, sys_power, sys_eff}, 64'd0);
        chk("rst_sys_ready", sys_ready, 1'b0);
        chk("rst_csr", {bus.csr_ready, bus.csr_err, bus.csr_rdata}, 64'd0);
        chk("rst_tvalid", bus.tile_csr_valid, '0);
        reset = 1'b0;

        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            tile_ready = rdy_pat[j];
            @(negedge clk);
            chk($sformatf("sys_ready%0d", j), sys_ready, rdy_exp[j]);
        end
        tile_ready = 4'b1111;

        for (int j = 0; j < 12; j++)
            run_snap(vt[j].ops, vt[j].pwr, vt[j].e_ops, vt[j].e_pwr, vt[j].e_eff,
                     $sformatf("snap%0d", j));

        // snap_req held high: back-to-back snapshots, one done per snapshot
        @(negedge clk);
        ops_in = vt[0].ops; pwr_in = vt[0].pwr; snap_req = 1'b1;
        nd = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (snap_done) nd++;
        end
        chk("b2b_done_count", nd, 2);
        snap_req = 1'b0;
        nd = 0; k = 0;
        while (snap_busy && k < 100) begin
            @(negedge clk);
            if (snap_done) nd++;
            k++;
        end
        chk("b2b_drain_done", nd, 1);
        chk("b2b_idle", snap_busy, 1'b0);
        chk("b2b_eff", sys_eff, vt[0].e_eff);

        // CSR: read tile 3 (addr 0xC4) answering after 5 cycles
        t_dly[3] = 5; t_val[3] = 32'h1234;
        csr_txn(1'b0, 1'b0, 8'hC4, 32'd0, 4'b1000, 32'h1234, 1'b0, -1, "rd3");
        // broadcast flag on a read behaves as a plain read
        t_val[2] = 32'h2222;
        csr_txn(1'b0, 1'b1, 8'h80, 32'd0, 4'b0100, 32'h2222, 1'b0, -1, "bcrd2");
        // single write to tile 1
        for (int i = 0; i < NT; i++) wc[i] = wr_count[i];
        csr_txn(1'b1, 1'b0, 8'h40, 32'hA5A5, 4'b0010, 32'd0, 1'b0, -1, "wr1");
        chk("wr1_seen", {wr_count[0] - wc[0], wr_count[1] - wc[1],
                         wr_count[2] - wc[2], wr_count[3] - wc[3]}, {32'd0, 32'd1, 32'd0, 32'd0});
        // CSR read concurrent with a snapshot
        t_dly[0] = 1; t_val[0] = 32'hCAFE;
        fork
            run_snap(vt[4].ops, vt[4].pwr, vt[4].e_ops, vt[4].e_pwr, vt[4].e_eff, "conc_snap");
            csr_txn(1'b0, 1'b0, 8'h10, 32'd0, 4'b0001, 32'hCAFE, 1'b0, -1, "conc_rd0");
        join
        // broadcast write with tile 1 silent -> timeout
        t_en[1] = 1'b0;
        for (int i = 0; i < NT; i++) wc[i] = wr_count[i];
        csr_txn(1'b1, 1'b1, 8'h00, 32'h5A5A, 4'b1111, 32'hDEAD_BEEF, 1'b1, TO, "bcwr_to");
        chk("bcwr_seen", {wr_count[0] - wc[0], wr_count[1] - wc[1],
                          wr_count[2] - wc[2], wr_count[3] - wc[3]}, {32'd1, 32'd0, 32'd1, 32'd1});

        // reset in the 10th DIV cycle while a CSR read is also pending
        @(negedge clk);
        ops_in = vt[0].ops; pwr_in = vt[0].pwr; snap_req = 1'b1;
        bus.csr_valid = 1'b1; bus.csr_write = 1'b0; bus.csr_bcast = 1'b0; bus.csr_addr = 8'h40;
        @(posedge clk);
        @(negedge clk);
        snap_req = 1'b0; bus.csr_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_tvalid", bus.tile_csr_valid, 4'b0010);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_snap", {snap_busy, snap_done, sys_ready}, 3'b000);
        chk("mid_rst_sys", {sys_ops, sys_power, sys_eff}, 64'd0);
        chk("mid_rst_csr", {bus.csr_ready, bus.csr_err, bus.csr_rdata}, 64'd0);
        chk("mid_rst_tvalid", bus.tile_csr_valid, '0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0; nr = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (snap_done) nd++;
            if (bus.csr_ready) nr++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_no_ready", nr, 0);
        t_en[1] = 1'b1;
        run_snap(vt[0].ops, vt[0].pwr, vt[0].e_ops, vt[0].e_pwr, vt[0].e_eff, "post_rst");
        csr_txn(1'b0, 1'b0, 8'h40, 32'd0, 4'b0010, 32'h1001, 1'b0, -1, "post_rst_rd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
